pipeline_sequencer: RTL
=======================

Name: pipeline_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline (F, D, E, M, W).
- Takes the single-cycle hazard requests (load-use stall, taken branch) together with two multi-cycle events: an iterative multiply in E and a data-memory wait in M.
- Drives per-stage hold and bubble controls into the pipeline registers.
- Sequences multi-cycle holds with an FSM and keeps saturating hazard performance counters.

Parameters:
- MUL_CYCLES, 4, cycles a multiply occupies E; legal range 2..15.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  load-use request from the hazard unit (instruction in D depends on a load in E)
- branchTaken  input  1  branch resolved taken in E
- mulStart  input  1  multiply instruction present in E this cycle (RUN state only)
- memWait  input  1  data memory not ready; instruction in M must hold
- clrCnt  input  1  synchronous clear of the performance counters and err
- stallF  output  1  hold the PC/F register
- stallD  output  1  hold the F/D register
- stallE  output  1  hold the D/E register
- stallM  output  1  hold the E/M register
- flushD  output  1  bubble into the F/D register
- flushE  output  1  bubble into the D/E register
- flushM  output  1  bubble into the E/M register
- flushW  output  1  bubble into the M/W register
- mulDone  output  1  one-cycle pulse in the final multiply cycle
- err  output  1  sticky protocol-error flag
- stallCount  output  CNT_W  cycles with stallF=1 (saturating)
- flushCount  output  CNT_W  cycles with flushD=1 or flushE=1 (saturating)

Behaviour:
- States: RUN, MUL. Registers: state, 4-bit cnt, stallCount, flushCount, err.
- Reset (reset=0, async): state=RUN, cnt=0, counters=0, err=0.
- While reset=0, all stall*/flush* outputs and mulDone are forced to 0.
- Outputs are combinational from state plus inputs, evaluated in this priority order.

1. memWait=1, any state:
   - stallF=stallD=stallE=stallM=1, flushW=1, all other flush*=0.
   - FSM and cnt hold; mulDone=0.
   - stall, branchTaken and mulStart are ignored.
2. RUN with mulStart=1:
   - stallF=stallD=stallE=1, flushM=1.
   - Next state=MUL, cnt<=MUL_CYCLES-2.
   - If branchTaken=1 in the same cycle: illegal. Set err<=1, the multiply path wins and the branch is ignored.
3. MUL:
   - stallF=stallD=stallE=1, flushM=1.
   - cnt==0: mulDone=1, next state=RUN. Otherwise cnt<=cnt-1.
   - stall, branchTaken and mulStart are ignored; branchTaken=1 here sets err<=1.
   - Net effect: the multiply holds E for exactly MUL_CYCLES cycles and inserts MUL_CYCLES bubbles into M.
4. RUN with branchTaken=1: flushD=1, flushE=1, no stalls. The branch overrides a simultaneous stall, so the load-use bubble is absorbed by flushE.
5. RUN with stall=1: stallF=1, stallD=1, flushE=1.
6. Otherwise all stall/flush outputs are 0.

- Counters:
  - Increment at the clock edge when the qualifying output is 1.
  - Saturate at all-ones.
  - clrCnt=1 clears both counters and err at the next edge, overriding any increment that cycle.
- Async reset asserted mid-MUL: return immediately to RUN with cnt=0. No mulDone is issued for the aborted multiply.

Test Plan:
1. Reset low for 2 cycles with stall=1, then release and hold stall=1 for 1 cycle → outputs 0 during reset; after release stallF=stallD=flushE=1 for that cycle; stallCount=1, flushCount=1.
2. MUL_CYCLES=4, pulse mulStart for 1 cycle → stallF/D/E and flushM high for 4 consecutive cycles, mulDone high only in the 4th, state back to RUN in the 5th.
3. During a multiply, assert memWait for 3 cycles in the 2nd MUL cycle → all stalls and flushW high, cnt frozen; multiply completes 3 cycles later than test 2 (7 hold cycles total); flushM low during the wait.
4. stall=1 and branchTaken=1 together in RUN → flushD=flushE=1, stallF=stallD=0; flushCount +1, stallCount unchanged.
5. mulStart=1 with branchTaken=1 → err=1 thereafter and MUL entered; then clrCnt=1 → err=0 and counters=0 next cycle.
6. CNT_W=4, stall held 20 cycles → stallCount saturates at 15; drop reset mid-sequence → counters 0 asynchronously.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: single-cycle hazards, iterative
// multiply hold in E, data-memory wait in M, plus saturating hazard counters.
module pipeline_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic             mulStart,
    input  logic             memWait,
    input  logic             clrCnt,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             mulDone,
    output logic             err,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic {RUN, MUL} state_t;

    // The start cycle counts as the first of MUL_CYCLES hold cycles.
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_cnt;
    logic [3:0]       w_next_cnt;
    logic             r_err;
    logic             w_err_set;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_err_set    = 1'b0;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        flushW       = 1'b0;
        mulDone      = 1'b0;
        if (!reset) begin
            w_next_state = RUN;
        end else if (memWait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (r_state == RUN && mulStart) begin
            stallF       = 1'b1;
            stallD       = 1'b1;
            stallE       = 1'b1;
            flushM       = 1'b1;
            w_next_state = MUL;
            w_next_cnt   = CNT_INIT;
            w_err_set    = branchTaken;
        end else if (r_state == MUL) begin
            stallF    = 1'b1;
            stallD    = 1'b1;
            stallE    = 1'b1;
            flushM    = 1'b1;
            w_err_set = branchTaken;
            if (r_cnt == 4'd0) begin
                mulDone      = 1'b1;
                w_next_state = RUN;
            end else begin
                w_next_cnt = r_cnt - 4'd1;
            end
        end else if (branchTaken) begin
            // A taken branch also squashes the instruction a load-use stall would hold.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_cnt       <= 4'd0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (clrCnt) begin
                r_err       <= 1'b0;
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_err_set) r_err <= 1'b1;
                if (stallF) r_stall_cnt <= sat_inc(r_stall_cnt);
                if (flushD || flushE) r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign err        = r_err;
    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;

endmodule
